inst_fifo: RTL and testbench

Dual-ported instruction queue between the instruction cache and the dual-issue decode stage. It accepts up to two instructions per cycle from the cache's `inst_data_ok1/2` / `inst_rdata1/2` outputs and presents up to two oldest instructions per cycle to decode. It decouples fetch from issue stalls, and it produces the `full` back-pressure that becomes part of the fetch-stage stall. A flush discards all queued instructions after a redirect such as a branch mispredict or an exception.

---
 rtl/inst_fifo.sv | 102 ++++++++++
 tb/tb_inst_fifo.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fifo.sv
// Dual-ported instruction queue between the I-cache and dual-issue decode.
// Accepts up to two instructions per cycle and presents the two oldest entries.
module inst_fifo #(
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned PTR_WIDTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        in_valid1,
   input  logic        in_valid2,
   input  logic [31:0] in_inst1,
   input  logic [31:0] in_inst2,
   input  logic [31:0] in_pc1,
   input  logic        pop1,
   input  logic        pop2,
   output logic        out_valid1,
   output logic        out_valid2,
   output logic [31:0] out_inst1,
   output logic [31:0] out_inst2,
   output logic [31:0] out_pc1,
   output logic [31:0] out_pc2,
   output logic        full,
   output logic        empty
);

   localparam int unsigned CW = PTR_WIDTH + 1;

   logic [31:0]          mem_pc   [DEPTH];
   logic [31:0]          mem_inst [DEPTH];
   logic [PTR_WIDTH-1:0] wr_ptr;
   logic [PTR_WIDTH-1:0] rd_ptr;
   logic [CW-1:0]        count;
   logic [PTR_WIDTH-1:0] wr_ptr_p1;
   logic [PTR_WIDTH-1:0] rd_ptr_p1;
   logic [1:0]           push_n;
   logic [1:0]           pop_req;
   logic [1:0]           pop_n;

   assign wr_ptr_p1 = wr_ptr + PTR_WIDTH'(1);
   assign rd_ptr_p1 = rd_ptr + PTR_WIDTH'(1);

   assign full  = (count >= CW'(DEPTH - 1));
   assign empty = (count == '0);

   // A push is all-or-nothing: a full queue drops both slots.
   always_comb begin
      push_n = 2'd0;
      if (!full && !flush && in_valid1) begin
         push_n = in_valid2 ? 2'd2 : 2'd1;
      end
   end

   // Pop is clamped to the registered count, ignoring this cycle's push.
   always_comb begin
      pop_req = 2'd0;
      if (pop1) begin
         pop_req = pop2 ? 2'd2 : 2'd1;
      end
      pop_n = pop_req;
      if (count < CW'(pop_req)) begin
         pop_n = count[1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (push_n != 2'd0) begin
         mem_pc[wr_ptr]   <= in_pc1;
         mem_inst[wr_ptr] <= in_inst1;
      end
      if (push_n == 2'd2) begin
         mem_pc[wr_ptr_p1]   <= in_pc1 + 32'd4;
         mem_inst[wr_ptr_p1] <= in_inst2;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + PTR_WIDTH'(push_n);
         rd_ptr <= rd_ptr + PTR_WIDTH'(pop_n);
         count  <= count + CW'(push_n) - CW'(pop_n);
      end
   end

   always_comb begin
      out_valid1 = (count >= CW'(1));
      out_valid2 = (count >= CW'(2));
      out_inst1  = out_valid1 ? mem_inst[rd_ptr]    : 32'd0;
      out_pc1    = out_valid1 ? mem_pc[rd_ptr]      : 32'd0;
      out_inst2  = out_valid2 ? mem_inst[rd_ptr_p1] : 32'd0;
      out_pc2    = out_valid2 ? mem_pc[rd_ptr_p1]   : 32'd0;
   end

endmodule

// File: tb/tb_inst_fifo.sv
// Directed self-checking bench for inst_fifo: reset, fill, pop clamp, wrap,
// flush priority and asynchronous reset.
module tb_inst_fifo;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid1;
   logic        in_valid2;
   logic [31:0] in_inst1;
   logic [31:0] in_inst2;
   logic [31:0] in_pc1;
   logic        pop1;
   logic        pop2;
   logic        out_valid1;
   logic        out_valid2;
   logic [31:0] out_inst1;
   logic [31:0] out_inst2;
   logic [31:0] out_pc1;
   logic [31:0] out_pc2;
   logic        full;
   logic        empty;

   int total = 0;
   int bad   = 0;

   inst_fifo #(.DEPTH(16), .PTR_WIDTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid1 (in_valid1),
      .in_valid2 (in_valid2),
      .in_inst1  (in_inst1),
      .in_inst2  (in_inst2),
      .in_pc1    (in_pc1),
      .pop1      (pop1),
      .pop2      (pop2),
      .out_valid1(out_valid1),
      .out_valid2(out_valid2),
      .out_inst1 (out_inst1),
      .out_inst2 (out_inst2),
      .out_pc1   (out_pc1),
      .out_pc2   (out_pc2),
      .full      (full),
      .empty     (empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v1, input logic v2, input logic [31:0] i1,
                        input logic [31:0] i2, input logic [31:0] pc,
                        input logic p1, input logic p2, input logic fl);
      in_valid1 = v1;
      in_valid2 = v2;
      in_inst1  = i1;
      in_inst2  = i2;
      in_pc1    = pc;
      pop1      = p1;
      pop2      = p2;
      flush     = fl;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
   endtask

   // Inputs change and outputs are sampled 1 ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] wpc(input int n);
      return 32'h0000_2000 + 32'(4 * n);
   endfunction

   function automatic logic [31:0] winst(input int n);
      return 32'hC0DE_0000 + 32'(n);
   endfunction

   initial begin
      int r;
      int w;
      rst = 1'b1;
      idle();
      tick();
      tick();
      chk("rst_valid1", {31'd0, out_valid1}, 32'd0);
      chk("rst_valid2", {31'd0, out_valid2}, 32'd0);
      chk("rst_empty", {31'd0, empty}, 32'd1);
      chk("rst_full", {31'd0, full}, 32'd0);
      chk("rst_inst1", out_inst1, 32'd0);
      chk("rst_pc1", out_pc1, 32'd0);
      rst = 1'b0;

      // Single pair push after reset.
      drive(1'b1, 1'b1, 32'h1111_1111, 32'h2222_2222, 32'hBFC0_0000, 1'b0, 1'b0, 1'b0);
      tick();
      idle();
      chk("push_valid1", {31'd0, out_valid1}, 32'd1);
      chk("push_valid2", {31'd0, out_valid2}, 32'd1);
      chk("push_pc1", out_pc1, 32'hBFC0_0000);
      chk("push_pc2", out_pc2, 32'hBFC0_0004);
      chk("push_inst1", out_inst1, 32'h1111_1111);
      chk("push_inst2", out_inst2, 32'h2222_2222);
      chk("push_empty", {31'd0, empty}, 32'd0);

      // Pop one, then a double pop with count=1 is clamped to one.
      drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
      tick();
      idle();
      chk("pop1_inst1", out_inst1, 32'h2222_2222);
      chk("pop1_pc1", out_pc1, 32'hBFC0_0004);
      chk("pop1_valid2", {31'd0, out_valid2}, 32'd0);
      chk("pop1_inst2", out_inst2, 32'd0);
      drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
      tick();
      idle();
      chk("clamp_empty", {31'd0, empty}, 32'd1);
      chk("clamp_valid1", {31'd0, out_valid1}, 32'd0);
      chk("clamp_inst1", out_inst1, 32'd0);

      // Fill: one single then seven pairs gives count 15 and raises full.
      drive(1'b1, 1'b0, 32'h100, 32'd0, 32'h1000, 1'b0, 1'b0, 1'b0);
      tick();
      chk("fill_full_c1", {31'd0, full}, 32'd0);
      for (int k = 0; k < 7; k++) begin
         drive(1'b1, 1'b1, 32'h101 + 32'(2 * k), 32'h102 + 32'(2 * k),
               32'h1004 + 32'(8 * k), 1'b0, 1'b0, 1'b0);
         tick();
         chk($sformatf("fill_full_k%0d", k), {31'd0, full}, (k == 6) ? 32'd1 : 32'd0);
      end
      drive(1'b1, 1'b1, 32'hDEAD_DEAD, 32'hBEEF_BEEF, 32'hFFFF_0000, 1'b0, 1'b0, 1'b0);
      tick();
      idle();
      chk("blocked_full", {31'd0, full}, 32'd1);
      chk("blocked_inst1", out_inst1, 32'h100);
      chk("blocked_pc1", out_pc1, 32'h1000);
      // Drain in pairs; exactly 15 entries in order, none from the blocked push.
      for (int j = 0; j < 7; j++) begin
         chk($sformatf("drain_inst1_%0d", j), out_inst1, 32'h100 + 32'(2 * j));
         chk($sformatf("drain_pc2_%0d", j), out_pc2, 32'h1004 + 32'(8 * j));
         drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
         tick();
         idle();
      end
      chk("drain_last_inst1", out_inst1, 32'h10E);
      chk("drain_last_valid2", {31'd0, out_valid2}, 32'd0);
      drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b1, 1'b0);
      tick();
      idle();
      chk("drain_empty", {31'd0, empty}, 32'd1);

      // Wrap-around at steady count 3.
      drive(1'b1, 1'b1, winst(0), winst(1), wpc(0), 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 1'b0, winst(2), 32'd0, wpc(2), 1'b0, 1'b0, 1'b0);
      tick();
      r = 0;
      w = 3;
      for (int c = 0; c < 20; c++) begin
         chk($sformatf("wrap_pc1_%0d", c), out_pc1, wpc(r));
         chk($sformatf("wrap_inst2_%0d", c), out_inst2, winst(r + 1));
         drive(1'b1, 1'b1, winst(w), winst(w + 1), wpc(w), 1'b1, 1'b1, 1'b0);
         tick();
         r += 2;
         w += 2;
      end
      idle();
      chk("wrap_end_pc1", out_pc1, wpc(r));
      chk("wrap_end_pc2", out_pc2, wpc(r + 1));

      // Count 5, then push, pop and flush together.
      drive(1'b1, 1'b1, winst(w), winst(w + 1), wpc(w), 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 1'b1, 32'h5555_5555, 32'h6666_6666, 32'h4000, 1'b1, 1'b1, 1'b1);
      chk("flush_cycle_valid1", {31'd0, out_valid1}, 32'd1);
      tick();
      idle();
      chk("flush_valid1", {31'd0, out_valid1}, 32'd0);
      chk("flush_empty", {31'd0, empty}, 32'd1);
      drive(1'b1, 1'b0, 32'hAAAA_AAAA, 32'd0, 32'h3000, 1'b0, 1'b0, 1'b0);
      tick();
      idle();
      chk("postflush_inst1", out_inst1, 32'hAAAA_AAAA);
      chk("postflush_pc1", out_pc1, 32'h3000);
      chk("postflush_valid2", {31'd0, out_valid2}, 32'd0);

      // Build count 6, then assert reset between edges.
      drive(1'b1, 1'b1, 32'h7, 32'h8, 32'h5000, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 1'b1, 32'h9, 32'hA, 32'h5008, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 1'b0, 32'hB, 32'd0, 32'h5010, 1'b0, 1'b0, 1'b0);
      tick();
      idle();
      chk("pre_arst_valid2", {31'd0, out_valid2}, 32'd1);
      chk("pre_arst_full", {31'd0, full}, 32'd0);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_empty", {31'd0, empty}, 32'd1);
      chk("arst_valid1", {31'd0, out_valid1}, 32'd0);
      chk("arst_valid2", {31'd0, out_valid2}, 32'd0);
      chk("arst_inst1", out_inst1, 32'd0);
      rst = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
